// File: rtl/audio_pkg.sv
`default_nettype none
// ==========================================================================
// audio_pkg : shared types and constants for the wavetable audio path
// Rev 1.0
// ==========================================================================
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [3:0] VOL_MUTE   = 4'hF;
  localparam int         FRAME_CLKS = 32;

  // The whole sequence must finish before the driver's next frame request.
  function automatic bit latency_ok(input int nch, input int rom_lat);
    return (2 + nch * (rom_lat + 1)) < FRAME_CLKS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wavetable_player_if.sv
`default_nettype none
// ==========================================================================
// wavetable_player_if : control, ROM and sample bus of the wavetable player
// Rev 1.0
// ==========================================================================
interface wavetable_player_if #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 16,
  parameter int NCH     = 2
);
  logic                   req;
  logic                   enable;
  logic [NCH*PHASE_W-1:0] freq_word;
  logic [NCH*4-1:0]       vol;
  logic [ADDR_W-1:0]      rom_addr;
  logic [DATA_W-1:0]      rom_data;
  logic [NCH*DATA_W-1:0]  sample;
  logic                   sample_valid;
  logic                   busy;
  logic                   overrun;

  modport master (
    output req, enable, freq_word, vol, rom_data,
    input  rom_addr, sample, sample_valid, busy, overrun
  );

  modport slave (
    input  req, enable, freq_word, vol, rom_data,
    output rom_addr, sample, sample_valid, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/wt_quadrant_map.sv
`default_nettype none
// ==========================================================================
// wt_quadrant_map : phase to table address / negate flag, full or quarter wave
// Rev 1.0
// ==========================================================================
module wt_quadrant_map #(
  parameter int ADDR_W  = 8,
  parameter int PHASE_W = 16,
  parameter int QUARTER = 0
) (
  input  wire  [PHASE_W-1:0] phase,
  output logic [ADDR_W-1:0]  addr,
  output logic               negate
);
  logic unused_phase;
  assign unused_phase = ^phase;

  generate
    if (QUARTER != 0) begin : g_quarter
      logic [1:0]        quad;
      logic [ADDR_W-1:0] idx;
      assign quad = phase[PHASE_W-1 -: 2];
      assign idx  = phase[PHASE_W-3 -: ADDR_W];
      // Odd quadrants run the table backwards, the second half-period is negated.
      assign addr   = quad[0] ? ~idx : idx;
      assign negate = quad[1];
    end else begin : g_full
      assign addr   = phase[PHASE_W-1 -: ADDR_W];
      assign negate = 1'b0;
    end
  endgenerate
endmodule
`default_nettype wire

// File: rtl/wavetable_player.sv
`default_nettype none
// ==========================================================================
// wavetable_player : NCH-channel DDS sharing one synchronous wavetable ROM
// Rev 1.0
// ==========================================================================
module wavetable_player
  import audio_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 16,
  parameter int NCH     = 2,
  parameter int ROM_LAT = 1,
  parameter int QUARTER = 0
) (
  input wire                clk_1p5m_w,
  input wire                rst_n,
  wavetable_player_if.slave bus
);
  localparam int              CH_W     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NCH - 1);
  localparam logic [1:0]      LAT_LAST = 2'(ROM_LAT - 1);

  generate
    if (!latency_ok(NCH, ROM_LAT) || ROM_LAT < 1 || ROM_LAT > 4 ||
        PHASE_W < ADDR_W + 2) begin : g_param_check
      $error("wavetable_player: unsupported parameter set");
    end
  endgenerate

  state_t                      state, state_nx;
  logic                        load_addr, capture, commit;
  logic [CH_W-1:0]             ch, sel_ch;
  logic [1:0]                  lat_cnt;
  logic [NCH-1:0][PHASE_W-1:0] phase, freq_q, freq_arr;
  logic [NCH-1:0][3:0]         vol_arr;
  logic [NCH-1:0][DATA_W-1:0]  shadow, sample_r;
  logic [ADDR_W-1:0]           rom_addr_r, map_addr;
  logic                        map_neg, neg_cur, sample_valid_r, overrun_r;
  logic [3:0]                  vol_cur;
  logic [DATA_W-1:0]           neg_data, att_data;

  assign freq_arr = bus.freq_word;
  assign vol_arr  = bus.vol;

  // The address for the next channel is loaded on the edge that enters ADDR,
  // so the ROM sees it for the full ADDR + WAIT window.
  always_comb begin
    sel_ch = '0;
    if (state == WAIT && ch != CH_LAST) sel_ch = ch + CH_W'(1);
  end

  wt_quadrant_map #(
    .ADDR_W  (ADDR_W),
    .PHASE_W (PHASE_W),
    .QUARTER (QUARTER)
  ) u_map (
    .phase  (phase[sel_ch]),
    .addr   (map_addr),
    .negate (map_neg)
  );

  always_comb begin
    neg_data = neg_cur ? -bus.rom_data : bus.rom_data;
    att_data = '0;
    if (vol_cur != VOL_MUTE) att_data = $signed(neg_data) >>> vol_cur;
  end

  always_ff @(posedge clk_1p5m_w or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load_addr = 1'b0;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          state_nx  = ADDR;
          load_addr = 1'b1;
        end
      end
      ADDR: state_nx = WAIT;
      WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          capture = 1'b1;
          if (ch == CH_LAST) begin
            state_nx = COMMIT;
          end else begin
            state_nx  = ADDR;
            load_addr = 1'b1;
          end
        end
      end
      COMMIT: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_1p5m_w or negedge rst_n) begin
    if (!rst_n) begin
      ch             <= '0;
      lat_cnt        <= '0;
      rom_addr_r     <= '0;
      neg_cur        <= 1'b0;
      vol_cur        <= '0;
      freq_q         <= '0;
      phase          <= '0;
      shadow         <= '0;
      sample_r       <= '0;
      sample_valid_r <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      sample_valid_r <= commit;
      if (bus.req && state != IDLE) overrun_r <= 1'b1;
      if (load_addr) begin
        rom_addr_r <= map_addr;
        neg_cur    <= map_neg;
        ch         <= sel_ch;
      end
      if (state == ADDR) begin
        vol_cur    <= vol_arr[ch];
        freq_q[ch] <= freq_arr[ch];
        lat_cnt    <= '0;
      end
      if (state == WAIT) lat_cnt <= lat_cnt + 2'd1;
      if (capture) shadow[ch] <= att_data;
      if (commit) begin
        sample_r <= bus.enable ? shadow : '0;
        if (bus.enable) begin
          for (int k = 0; k < NCH; k++) phase[k] <= phase[k] + freq_q[k];
        end
      end
    end
  end

  assign bus.rom_addr     = rom_addr_r;
  assign bus.sample       = sample_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.busy         = (state != IDLE);
  assign bus.overrun      = overrun_r;
endmodule
`default_nettype wire

// File: tb/tb_wavetable_player.sv
`default_nettype none
// ==========================================================================
// tb_wavetable_player : scoreboard bench for full-table and quarter-wave players
// Rev 1.0
// ==========================================================================
module tb_wavetable_player;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, enable;
  logic [31:0] freq;
  logic [7:0]  vol;
  int          checks = 0, failures = 0, sv_cnt_f = 0, sv_cnt_q = 0, base;
  logic [15:0] rom_f [256];
  logic [15:0] rom_q [64];
  logic [15:0] mph [2];
  logic [31:0] sb_f [$];
  logic [31:0] sb_q [$];

  always #5 clk = ~clk;

  wavetable_player_if #(.ADDR_W(8), .DATA_W(16), .PHASE_W(16), .NCH(2)) bus_f ();
  wavetable_player_if #(.ADDR_W(6), .DATA_W(16), .PHASE_W(16), .NCH(2)) bus_q ();

  assign bus_f.req = req;       assign bus_q.req = req;
  assign bus_f.enable = enable; assign bus_q.enable = enable;
  assign bus_f.freq_word = freq; assign bus_q.freq_word = freq;
  assign bus_f.vol = vol;       assign bus_q.vol = vol;

  wavetable_player #(.ADDR_W(8), .DATA_W(16), .PHASE_W(16), .NCH(2), .ROM_LAT(1), .QUARTER(0))
    dut_f (.clk_1p5m_w(clk), .rst_n(rst_n), .bus(bus_f.slave));
  wavetable_player #(.ADDR_W(6), .DATA_W(16), .PHASE_W(16), .NCH(2), .ROM_LAT(1), .QUARTER(1))
    dut_q (.clk_1p5m_w(clk), .rst_n(rst_n), .bus(bus_q.slave));

  // Synchronous ROMs, one clock of read latency.
  always @(posedge clk) begin
    bus_f.rom_data <= rom_f[bus_f.rom_addr];
    bus_q.rom_data <= rom_q[bus_q.rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] atten(input logic [15:0] d, input logic [3:0] v);
    logic signed [15:0] s;
    s = d;
    if (v == 4'hF) return 16'h0000;
    return 16'(s >>> v);
  endfunction

  function automatic logic [15:0] quarter_entry(input logic [15:0] ph);
    logic [5:0]  idx;
    logic [15:0] d;
    idx = ph[14] ? ~ph[13:8] : ph[13:8];
    d   = rom_q[idx];
    return ph[15] ? 16'(-d) : d;
  endfunction

  task automatic push_expect();
    logic [15:0] ef [2];
    logic [15:0] eq [2];
    for (int k = 0; k < 2; k++) begin
      if (enable) begin
        ef[k]  = atten(rom_f[mph[k][15:8]], vol[k*4 +: 4]);
        eq[k]  = atten(quarter_entry(mph[k]), vol[k*4 +: 4]);
        mph[k] = mph[k] + freq[k*16 +: 16];
      end else begin
        ef[k] = 16'h0000;
        eq[k] = 16'h0000;
      end
    end
    sb_f.push_back({ef[1], ef[0]});
    sb_q.push_back({eq[1], eq[0]});
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_f.sample_valid) begin
      sv_cnt_f++;
      if (sb_f.size() == 0) begin
        checks++; failures++;
        $error("FAIL sb_f_unexpected observed=%0h expected=none", bus_f.sample);
      end else check("sample_f", bus_f.sample, sb_f.pop_front());
    end
    if (rst_n && bus_q.sample_valid) begin
      sv_cnt_q++;
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $error("FAIL sb_q_unexpected observed=%0h expected=none", bus_q.sample);
      end else check("sample_q", bus_q.sample, sb_q.pop_front());
    end
  end

  // One 32-clock frame, starting and ending on a falling edge.
  task automatic frame();
    int lat, k;
    lat = 0; k = 0;
    req = 1'b1;
    push_expect();
    @(negedge clk);
    req = 1'b0;
    while (k < 30 && lat == 0) begin
      @(negedge clk);
      k++;
      if (bus_f.sample_valid) begin
        lat = k + 1;
        check("valid_q_aligned", 32'(bus_q.sample_valid), 32'd1);
      end
    end
    check("latency", 32'(lat), 32'd6);
    repeat (31 - k) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_f[i] = 16'(i * 128);
    for (int i = 0; i < 64; i++)  rom_q[i] = 16'(i * 256);
    rst_n = 1'b0; req = 1'b0; enable = 1'b1;
    freq = {16'h8000, 16'h0100};
    vol  = {4'd2, 4'd0};
    mph[0] = '0; mph[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_sample_f", bus_f.sample, 32'd0);
    check("rst_sample_q", bus_q.sample, 32'd0);
    check("rst_valid", 32'(bus_f.sample_valid), 32'd0);
    check("rst_busy", 32'(bus_f.busy), 32'd0);
    check("rst_overrun", 32'(bus_f.overrun), 32'd0);
    check("rst_addr", 32'(bus_f.rom_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 258; n++) begin
      frame();
      if (n == 10)  check("q_frame10",  32'(bus_q.sample[15:0]), 32'h0A00);
      if (n == 70)  check("q_frame70",  32'(bus_q.sample[15:0]), 32'h3900);
      if (n == 130) check("q_frame130", 32'(bus_q.sample[15:0]), 32'hFE00);
      if (n == 200) check("q_frame200", 32'(bus_q.sample[15:0]), 32'hC900);
      if (n == 255) check("f_top",      32'(bus_f.sample[15:0]), 32'h7F80);
      if (n == 256) check("f_wrap",     32'(bus_f.sample[15:0]), 32'h0000);
      if (n == 257) check("f_wrap1",    32'(bus_f.sample[15:0]), 32'h0080);
    end

    // Reset three clocks into a frame.
    freq = {16'h4000, 16'h0100};
    rom_f[64] = 16'hC000;
    req = 1'b1;
    push_expect();
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_mid", 32'(bus_f.busy), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sample_f", bus_f.sample, 32'd0);
    check("midrst_sample_q", bus_q.sample, 32'd0);
    check("midrst_busy_f", 32'(bus_f.busy), 32'd0);
    check("midrst_busy_q", 32'(bus_q.busy), 32'd0);
    check("midrst_addr", 32'(bus_f.rom_addr), 32'd0);
    sb_f.delete(); sb_q.delete();
    mph[0] = '0; mph[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Volume and mute on ch1 while ch0 keeps sweeping unattenuated.
    for (int n = 0; n < 12; n++) begin
      if (n == 8) vol = {4'hF, 4'd0};
      frame();
      if (n == 1) check("vol2_neg", 32'(bus_f.sample[31:16]), 32'hF000);
      if (n == 2) check("vol2_pos", 32'(bus_f.sample[31:16]), 32'h1000);
      if (n == 2) check("vol_ch0_indep", 32'(bus_f.sample[15:0]), 32'h0100);
      if (n == 9) check("mute_ch1", 32'(bus_f.sample[31:16]), 32'h0000);
      if (n == 9) check("mute_ch0_indep", 32'(bus_f.sample[15:0]), 32'h0480);
    end

    // Enable hold: silence and frozen phases, then resume at index 12.
    vol = {4'd2, 4'd0};
    enable = 1'b0;
    for (int n = 0; n < 3; n++) begin
      frame();
      check("hold_silent", bus_f.sample, 32'd0);
    end
    enable = 1'b1;
    frame();
    check("resume_ch0", 32'(bus_f.sample[15:0]), 32'h0600);

    // Second request three clocks after the first.
    check("ovr_before", 32'(bus_f.overrun), 32'd0);
    base = sv_cnt_f;
    req = 1'b1;
    push_expect();
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (28) @(negedge clk);
    check("ovr_f", 32'(bus_f.overrun), 32'd1);
    check("ovr_q", 32'(bus_q.overrun), 32'd1);
    check("ovr_one_valid", 32'(sv_cnt_f - base), 32'd1);
    check("ovr_idle", 32'(bus_f.busy), 32'd0);
    check("ovr_sample", 32'(bus_f.sample[15:0]), 32'h0680);
    check("sb_drained", 32'(sb_f.size() + sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
